// File: rtl/musicbox_pkg.sv
// Shared types and constants for the music-box playback path.
package musicbox_pkg;

  localparam int NOTE_W = 8;
  localparam int ADDR_W = 8;

  localparam logic [NOTE_W-1:0] NOTE_REST = 8'd0;

  localparam int SONG0_LEN_DEF = 196;
  localparam int SONG1_LEN_DEF = 243;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Address of the final step of a song with the given length.
  function automatic logic [ADDR_W-1:0] last_addr(input int len);
    return ADDR_W'(len - 1);
  endfunction

endpackage

// File: rtl/song_sequencer_beat_counter.sv
// beat_counter: modulo-MODULUS up-counter with clear and hold.
// prefetch fires on the advance into MODULUS-2, wrap on the advance from
// MODULUS-1 back to 0. count_next exposes the value after this edge.
module beat_counter #(
  parameter int MODULUS = 4,
  parameter int W       = $clog2(MODULUS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         hold,
  output logic [W-1:0] count_next,
  output logic         prefetch,
  output logic         wrap
);

  localparam logic [W-1:0] TC = W'(MODULUS - 1);
  localparam logic [W-1:0] PF = W'(MODULUS - 3);

  logic [W-1:0] count;
  logic         advance;

  // Next-count and edge flags; clear beats hold.
  always_comb begin
    advance  = !clear && !hold;
    wrap     = advance && (count == TC);
    prefetch = advance && (count == PF);
    if (clear)
      count_next = '0;
    else if (hold)
      count_next = count;
    else if (count == TC)
      count_next = '0;
    else
      count_next = count + W'(1);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: play/pause/stop/loop control for the two song ROMs.
// Optional build macro MUSICBOX_GAP_EN mutes note_out for the final
// GAP_CYCLES of each step so repeated notes are heard separately.
//
// state | meaning
// IDLE  | stopped, outputs at rest
// PRIME | two-cycle ROM fill before the first note
// PLAY  | stepping through the song, one step per beat
// PAUSE | beat count and address frozen, output muted
// DONE  | non-looping song finished
module song_sequencer
  import musicbox_pkg::*;
#(
  parameter int CYCLES_PER_BEAT = 12_500_000,
  parameter int SONG0_LEN       = SONG0_LEN_DEF,
  parameter int SONG1_LEN       = SONG1_LEN_DEF,
  parameter int GAP_CYCLES      = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              song_sel,
  input  logic              loop_en,
  input  logic [NOTE_W-1:0] rom_note,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_sel,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_strobe,
  output logic              playing,
  output logic              paused,
  output logic              done
);

  localparam int BEAT_W = $clog2(CYCLES_PER_BEAT);
  localparam logic [ADDR_W-1:0] LAST0 = last_addr(SONG0_LEN);
  localparam logic [ADDR_W-1:0] LAST1 = last_addr(SONG1_LEN);
  localparam logic [BEAT_W-1:0] GAP_START = BEAT_W'(CYCLES_PER_BEAT - GAP_CYCLES);
`ifdef MUSICBOX_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  state_t            state;
  logic              prime_ph;
  logic              end_pend;
  logic [NOTE_W-1:0] note_hold;
  logic [ADDR_W-1:0] last_step;
  logic              cnt_clear;
  logic              cnt_hold;
  logic [BEAT_W-1:0] beat_nx;
  logic              at_prefetch;
  logic              at_wrap;
  logic              gap_zone;

  // Counter control and per-song end address.
  always_comb begin
    last_step = rom_sel ? LAST1 : LAST0;
    cnt_clear = stop || !((state == PLAY) || (state == PAUSE));
    cnt_hold  = (state == PAUSE);
    gap_zone  = GAP_EN && (beat_nx >= GAP_START);
  end

  beat_counter #(
    .MODULUS (CYCLES_PER_BEAT),
    .W       (BEAT_W)
  ) u_beat (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .hold       (cnt_hold),
    .count_next (beat_nx),
    .prefetch   (at_prefetch),
    .wrap       (at_wrap)
  );

  // Playback FSM with registered outputs; stop > play > pause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      prime_ph    <= 1'b0;
      end_pend    <= 1'b0;
      rom_addr    <= '0;
      rom_sel     <= 1'b0;
      note_hold   <= NOTE_REST;
      note_out    <= NOTE_REST;
      note_strobe <= 1'b0;
      playing     <= 1'b0;
      paused      <= 1'b0;
      done        <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        prime_ph  <= 1'b0;
        end_pend  <= 1'b0;
        rom_addr  <= '0;
        note_hold <= NOTE_REST;
        note_out  <= NOTE_REST;
        playing   <= 1'b0;
        paused    <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (play) begin
              state    <= PRIME;
              rom_sel  <= song_sel;
              rom_addr <= '0;
              prime_ph <= 1'b0;
              end_pend <= 1'b0;
              note_out <= NOTE_REST;
              playing  <= 1'b1;
              done     <= 1'b0;
            end
          end
          PRIME: begin
            if (prime_ph) begin
              state       <= PLAY;
              note_hold   <= rom_note;
              note_out    <= rom_note;
              note_strobe <= 1'b1;
            end else begin
              prime_ph <= 1'b1;
            end
          end
          PLAY: begin
            // Address moves two cycles ahead of the wrap so the ROM output
            // is valid exactly when the new step starts.
            if (at_prefetch) begin
              if (rom_addr != last_step)
                rom_addr <= rom_addr + 8'd1;
              else if (loop_en)
                rom_addr <= '0;
              else
                end_pend <= 1'b1;
            end
            if (at_wrap && end_pend) begin
              state     <= DONE;
              note_hold <= NOTE_REST;
              note_out  <= NOTE_REST;
              playing   <= 1'b0;
              done      <= 1'b1;
            end else begin
              if (at_wrap) begin
                note_hold   <= rom_note;
                note_strobe <= 1'b1;
              end
              if (pause) begin
                state    <= PAUSE;
                note_out <= NOTE_REST;
                playing  <= 1'b0;
                paused   <= 1'b1;
              end else if (at_wrap) begin
                note_out <= gap_zone ? NOTE_REST : rom_note;
              end else begin
                note_out <= gap_zone ? NOTE_REST : note_hold;
              end
            end
          end
          PAUSE: begin
            if (play || pause) begin
              state    <= PLAY;
              note_out <= gap_zone ? NOTE_REST : note_hold;
              playing  <= 1'b1;
              paused   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
